// File: rtl/exc_pkg.sv
// Shared types and constants for the exception/interrupt flush sequencer.
// Holds the FSM state encoding, ExcCode values and the default trap vector.
package exc_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } exc_state_e;

    localparam logic [4:0]  EXC_INT = 5'd0;
    localparam logic [4:0]  EXC_SYS = 5'd8;

    localparam logic [31:0] DEF_TRAP_VECTOR = 32'h0000_0080;

endpackage

// File: rtl/irq_sync_edge.sv
// One external interrupt line: two-flop synchronizer followed by a
// rising-edge detector. All flops clear on reset.
module irq_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic irq_async,
    output logic irq_edge
);

    logic sync_1;
    logic sync_2;
    logic sync_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_1    <= irq_async;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
        end
    end

    assign irq_edge = sync_2 & ~sync_prev;

endmodule

// File: rtl/exc_flush_ctrl.sv
// Exception/interrupt sequencer at the ID boundary: arbitrates syscall, eret and
// interrupts, keeps minimal CP0 state and issues a one-cycle redirect + flush.
import exc_pkg::*;

module exc_flush_ctrl #(
    parameter logic [31:0] TRAP_VECTOR = DEF_TRAP_VECTOR,
    parameter int          NIRQ        = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic            id_stall,
    input  logic [31:0]     id_pc,
    input  logic            syscall_id,
    input  logic            eret_id,
    input  logic [NIRQ-1:0] irq,
    input  logic            mask_we,
    input  logic [NIRQ-1:0] mask_wdata,
    output logic            pc_redirect,
    output logic [31:0]     redirect_pc,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic [31:0]     epc,
    output logic [4:0]      exccode,
    output logic [NIRQ-1:0] pending,
    output logic            ie,
    output logic            in_handler
);

    exc_state_e      state;
    exc_state_e      state_next;
    logic [NIRQ-1:0] irq_edge;
    logic [NIRQ-1:0] mask;
    logic            boundary;
    logic            take_sys;
    logic            take_eret;
    logic            take_int;
    logic            take_any;
    logic [31:0]     target;

    for (genvar i = 0; i < NIRQ; i++) begin : g_irq
        irq_sync_edge u_sync (
            .clk       (clk),
            .rst       (rst),
            .irq_async (irq[i]),
            .irq_edge  (irq_edge[i])
        );
    end

    // Events are only taken on a real, non-stalled instruction while not
    // already flushing the wrong path.
    assign boundary  = (state == RUN) && id_valid && !id_stall;
    assign take_sys  = boundary && syscall_id;
    assign take_eret = boundary && !syscall_id && eret_id;
    assign take_int  = boundary && !syscall_id && !eret_id && ie && (|(pending & mask));
    assign take_any  = take_sys || take_eret || take_int;
    assign target    = take_eret ? epc : TRAP_VECTOR;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        pc_redirect = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        case (state)
            RUN: begin
                if (take_any) begin
                    state_next = REDIRECT;
                end
            end
            REDIRECT: begin
                pc_redirect = 1'b1;
                flush_ifid  = 1'b1;
                flush_idex  = 1'b1;
                state_next  = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_pc <= 32'h0;
            epc         <= 32'h0;
            exccode     <= EXC_INT;
            pending     <= '0;
            mask        <= '1;
            ie          <= 1'b1;
            in_handler  <= 1'b0;
        end else begin
            if (mask_we) begin
                mask <= mask_wdata;
            end

            // The handler services every line, but an edge landing in the
            // clearing cycle must survive.
            if (take_int) begin
                pending <= irq_edge;
            end else begin
                pending <= pending | irq_edge;
            end

            if (take_sys) begin
                epc        <= id_pc + 32'd4;
                exccode    <= EXC_SYS;
                ie         <= 1'b0;
                in_handler <= 1'b1;
            end else if (take_int) begin
                epc        <= id_pc;
                exccode    <= EXC_INT;
                ie         <= 1'b0;
                in_handler <= 1'b1;
            end else if (take_eret) begin
                ie         <= 1'b1;
                in_handler <= 1'b0;
            end

            if (take_any) begin
                redirect_pc <= target;
            end
        end
    end

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// Directed bench for exc_flush_ctrl: redirect/flush records go through an
// expected queue; CP0 state is checked with immediate assertions.
module tb_exc_flush_ctrl;

    localparam int NIRQ = 3;

    logic            clk;
    logic            rst;
    logic            id_valid;
    logic            id_stall;
    logic [31:0]     id_pc;
    logic            syscall_id;
    logic            eret_id;
    logic [NIRQ-1:0] irq;
    logic            mask_we;
    logic [NIRQ-1:0] mask_wdata;
    logic            pc_redirect;
    logic [31:0]     redirect_pc;
    logic            flush_ifid;
    logic            flush_idex;
    logic [31:0]     epc;
    logic [4:0]      exccode;
    logic [NIRQ-1:0] pending;
    logic            ie;
    logic            in_handler;

    int tests_run = 0;
    int tests_failed = 0;

    // {pc_redirect, flush_ifid, flush_idex, redirect_pc}
    logic [34:0] exp_q[$];

    exc_flush_ctrl #(
        .TRAP_VECTOR (32'h0000_0080),
        .NIRQ        (NIRQ)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_stall    (id_stall),
        .id_pc       (id_pc),
        .syscall_id  (syscall_id),
        .eret_id     (eret_id),
        .irq         (irq),
        .mask_we     (mask_we),
        .mask_wdata  (mask_wdata),
        .pc_redirect (pc_redirect),
        .redirect_pc (redirect_pc),
        .flush_ifid  (flush_ifid),
        .flush_idex  (flush_idex),
        .epc         (epc),
        .exccode     (exccode),
        .pending     (pending),
        .ie          (ie),
        .in_handler  (in_handler)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] strobes, input logic [31:0] pc);
        exp_q.push_back({strobes, pc});
    endtask

    task automatic step_and_check(input string tag);
        logic [34:0] e;
        @(posedge clk);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check({tag, "_qempty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, {29'd0, pc_redirect, flush_ifid, flush_idex, redirect_pc}, {29'd0, e});
        end
    endtask

    task automatic idle_inputs();
        id_valid   = 1'b0;
        id_stall   = 1'b0;
        syscall_id = 1'b0;
        eret_id    = 1'b0;
        mask_we    = 1'b0;
    endtask

    task automatic drive_id(input logic [31:0] pc, input logic sys, input logic er, input logic stall);
        id_valid   = 1'b1;
        id_pc      = pc;
        syscall_id = sys;
        eret_id    = er;
        id_stall   = stall;
    endtask

    initial begin
        rst        = 1'b1;
        id_pc      = 32'h0;
        irq        = '0;
        mask_wdata = '0;
        idle_inputs();
        repeat (2) @(negedge clk);

        check("rst_redirect", {63'd0, pc_redirect}, 64'd0);
        check("rst_flush", {62'd0, flush_ifid, flush_idex}, 64'd0);
        check("rst_rpc", {32'd0, redirect_pc}, 64'd0);
        check("rst_epc", {32'd0, epc}, 64'd0);
        check("rst_exccode", {59'd0, exccode}, 64'd0);
        check("rst_pending", {61'd0, pending}, 64'd0);
        check("rst_ie", {63'd0, ie}, 64'd1);
        check("rst_in_handler", {63'd0, in_handler}, 64'd0);
        rst = 1'b0;

        // Syscall at 0x40
        drive_id(32'h40, 1'b1, 1'b0, 1'b0);
        push_exp(3'b111, 32'h80);
        step_and_check("sys_redirect");
        check("sys_epc", {32'd0, epc}, 64'h44);
        check("sys_exccode", {59'd0, exccode}, 64'd8);
        check("sys_ie", {63'd0, ie}, 64'd0);
        check("sys_in_handler", {63'd0, in_handler}, 64'd1);

        // Syscall presented during REDIRECT must be ignored
        drive_id(32'h200, 1'b1, 1'b0, 1'b0);
        push_exp(3'b000, 32'h80);
        step_and_check("redirect_ignored");
        check("redirect_ignored_epc", {32'd0, epc}, 64'h44);

        // Eret back to EPC
        drive_id(32'h84, 1'b0, 1'b1, 1'b0);
        push_exp(3'b111, 32'h44);
        step_and_check("eret_redirect");
        check("eret_ie", {63'd0, ie}, 64'd1);
        check("eret_in_handler", {63'd0, in_handler}, 64'd0);
        check("eret_epc_kept", {32'd0, epc}, 64'h44);
        check("eret_exccode_kept", {59'd0, exccode}, 64'd8);
        idle_inputs();
        push_exp(3'b000, 32'h44);
        step_and_check("eret_strobe_off");

        // Interrupt on line 1 through the synchronizer
        irq = 3'b010;
        for (int i = 0; i < 3; i++) begin
            push_exp(3'b000, 32'h44);
            step_and_check("irq_sync_wait");
        end
        check("irq_pending_set", {61'd0, pending}, 64'h2);
        irq = 3'b000;
        drive_id(32'h100, 1'b0, 1'b0, 1'b0);
        push_exp(3'b111, 32'h80);
        step_and_check("int_redirect");
        check("int_epc", {32'd0, epc}, 64'h100);
        check("int_exccode", {59'd0, exccode}, 64'd0);
        check("int_pending_clr", {61'd0, pending}, 64'd0);
        check("int_ie", {63'd0, ie}, 64'd0);
        idle_inputs();
        push_exp(3'b000, 32'h80);
        step_and_check("int_strobe_off");
        drive_id(32'h80, 1'b0, 1'b1, 1'b0);
        push_exp(3'b111, 32'h100);
        step_and_check("int_eret");
        idle_inputs();
        push_exp(3'b000, 32'h100);
        step_and_check("int_eret_off");

        // Masked line: pending latches, no trap
        mask_we    = 1'b1;
        mask_wdata = 3'b101;
        push_exp(3'b000, 32'h100);
        step_and_check("mask_write");
        mask_we = 1'b0;
        irq     = 3'b010;
        for (int i = 0; i < 3; i++) begin
            push_exp(3'b000, 32'h100);
            step_and_check("masked_sync_wait");
        end
        irq = 3'b000;
        check("masked_pending", {61'd0, pending}, 64'h2);
        drive_id(32'h300, 1'b0, 1'b0, 1'b0);
        push_exp(3'b000, 32'h100);
        step_and_check("masked_no_trap");
        check("masked_pending_kept", {61'd0, pending}, 64'h2);

        // Stalled syscall blocked while the mask is reopened
        drive_id(32'h400, 1'b1, 1'b0, 1'b1);
        mask_we    = 1'b1;
        mask_wdata = 3'b111;
        push_exp(3'b000, 32'h100);
        step_and_check("stall_blocks");
        mask_we = 1'b0;

        // Syscall beats an enabled pending interrupt at the same boundary
        drive_id(32'h400, 1'b1, 1'b0, 1'b0);
        push_exp(3'b111, 32'h80);
        step_and_check("simul_sys_redirect");
        check("simul_exccode", {59'd0, exccode}, 64'd8);
        check("simul_epc", {32'd0, epc}, 64'h404);
        check("simul_pending_kept", {61'd0, pending}, 64'h2);
        idle_inputs();
        push_exp(3'b000, 32'h80);
        step_and_check("simul_off");

        // ie=0 in handler keeps the interrupt waiting
        drive_id(32'h80, 1'b0, 1'b0, 1'b0);
        push_exp(3'b000, 32'h80);
        step_and_check("handler_no_int");
        check("handler_in_handler", {63'd0, in_handler}, 64'd1);
        drive_id(32'h84, 1'b0, 1'b1, 1'b0);
        push_exp(3'b111, 32'h404);
        step_and_check("handler_eret");
        idle_inputs();
        push_exp(3'b000, 32'h404);
        step_and_check("handler_eret_off");
        drive_id(32'h404, 1'b0, 1'b0, 1'b0);
        push_exp(3'b111, 32'h80);
        step_and_check("late_int_redirect");
        check("late_int_exccode", {59'd0, exccode}, 64'd0);
        check("late_int_epc", {32'd0, epc}, 64'h404);
        check("late_int_pending", {61'd0, pending}, 64'd0);
        idle_inputs();

        // Reset in the middle of REDIRECT
        rst = 1'b1;
        #1;
        check("midrst_redirect", {63'd0, pc_redirect}, 64'd0);
        check("midrst_flush", {62'd0, flush_ifid, flush_idex}, 64'd0);
        check("midrst_ie", {63'd0, ie}, 64'd1);
        check("midrst_epc", {32'd0, epc}, 64'd0);
        check("midrst_rpc", {32'd0, redirect_pc}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Eret outside a handler still redirects to EPC
        drive_id(32'h10, 1'b0, 1'b1, 1'b0);
        push_exp(3'b111, 32'h0);
        step_and_check("stray_eret");
        check("stray_eret_ie", {63'd0, ie}, 64'd1);
        check("stray_eret_in_handler", {63'd0, in_handler}, 64'd0);
        idle_inputs();
        push_exp(3'b000, 32'h0);
        step_and_check("stray_eret_off");

        // EPC wraps modulo 2^32
        drive_id(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
        push_exp(3'b111, 32'h80);
        step_and_check("wrap_redirect");
        check("wrap_epc", {32'd0, epc}, 64'd0);
        idle_inputs();
        push_exp(3'b000, 32'h80);
        step_and_check("wrap_off");

        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
